// File: rtl/xc_sha2_pkg.sv
// rtl/xc_sha2_pkg.sv - shared encodings, rotate amounts and FSM states for the SHA-2 sigma unit
package xc_sha2_pkg;

  localparam logic [1:0] SS_S0  = 2'b00;
  localparam logic [1:0] SS_S1  = 2'b01;
  localparam logic [1:0] SS_BS0 = 2'b10;
  localparam logic [1:0] SS_BS1 = 2'b11;

  localparam logic ALG_SHA256 = 1'b0;
  localparam logic ALG_SHA512 = 1'b1;

  localparam int R256_S0_A  = 7;
  localparam int R256_S0_B  = 18;
  localparam int R256_S0_C  = 3;
  localparam int R256_S1_A  = 17;
  localparam int R256_S1_B  = 19;
  localparam int R256_S1_C  = 10;
  localparam int R256_BS0_A = 2;
  localparam int R256_BS0_B = 13;
  localparam int R256_BS0_C = 22;
  localparam int R256_BS1_A = 6;
  localparam int R256_BS1_B = 11;
  localparam int R256_BS1_C = 25;

  localparam int R512_S0_A  = 1;
  localparam int R512_S0_B  = 8;
  localparam int R512_S0_C  = 7;
  localparam int R512_S1_A  = 19;
  localparam int R512_S1_B  = 61;
  localparam int R512_S1_C  = 6;
  localparam int R512_BS0_A = 28;
  localparam int R512_BS0_B = 34;
  localparam int R512_BS0_C = 39;
  localparam int R512_BS1_A = 14;
  localparam int R512_BS1_B = 18;
  localparam int R512_BS1_C = 41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ONE  = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/xc_sha2_sigma_core.sv
// rtl/xc_sha2_sigma_core.sv - combinational SHA-256/SHA-512 sigma datapath
module xc_sha2_sigma_core
  import xc_sha2_pkg::*;
(
  input  logic [63:0] operand,
  input  logic        alg,
  input  logic [1:0]  ss,
  output logic [63:0] result
);

  logic [31:0] w;
  logic [31:0] r256;
  logic [63:0] r512;

  assign w = operand[31:0];

  always_comb begin
    r256 = '0;
    r512 = '0;
    case (ss)
      SS_S0: begin
        r256 = ror32(w, R256_S0_A) ^ ror32(w, R256_S0_B) ^ (w >> R256_S0_C);
        r512 = ror64(operand, R512_S0_A) ^ ror64(operand, R512_S0_B) ^ (operand >> R512_S0_C);
      end
      SS_S1: begin
        r256 = ror32(w, R256_S1_A) ^ ror32(w, R256_S1_B) ^ (w >> R256_S1_C);
        r512 = ror64(operand, R512_S1_A) ^ ror64(operand, R512_S1_B) ^ (operand >> R512_S1_C);
      end
      SS_BS0: begin
        r256 = ror32(w, R256_BS0_A) ^ ror32(w, R256_BS0_B) ^ ror32(w, R256_BS0_C);
        r512 = ror64(operand, R512_BS0_A) ^ ror64(operand, R512_BS0_B) ^ ror64(operand, R512_BS0_C);
      end
      default: begin
        r256 = ror32(w, R256_BS1_A) ^ ror32(w, R256_BS1_B) ^ ror32(w, R256_BS1_C);
        r512 = ror64(operand, R512_BS1_A) ^ ror64(operand, R512_BS1_B) ^ ror64(operand, R512_BS1_C);
      end
    endcase
  end

  // SHA-256 results are sign-extended so RV64 register writeback needs no extra step.
  assign result = (alg == ALG_SHA512) ? r512 : {{32{r256[31]}}, r256};

endmodule

// File: rtl/xc_sha2_sigma.sv
// rtl/xc_sha2_sigma.sv - SHA-2 sigma unit with valid/ready handshake and two-beat SHA-512 on RV32
module xc_sha2_sigma
  import xc_sha2_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit SHA512_EN = 1'b1
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_alg,
  input  logic [1:0]      req_ss,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_last,
  output logic            rsp_illegal
);

  state_t          state, state_nxt;
  logic            accept, two_beat, illegal;
  logic [63:0]     operand, core_res;
  logic [XLEN-1:0] res_q;
  logic [31:0]     hi_q;
  logic            last_q, ill_q;

  generate
    if (XLEN == 64) begin : g_x64
      logic unused_rs2;
      assign operand    = 64'(req_rs1);
      assign unused_rs2 = ^req_rs2;
    end else if (XLEN == 32) begin : g_x32
      assign operand = {req_rs2, req_rs1};
    end else begin : g_bad_xlen
      $error("xc_sha2_sigma: XLEN must be 32 or 64");
    end
  endgenerate

  xc_sha2_sigma_core u_core (
    .operand (operand),
    .alg     (req_alg),
    .ss      (req_ss),
    .result  (core_res)
  );

  assign two_beat = (XLEN == 32) && (req_alg == ALG_SHA512) && SHA512_EN;
  assign illegal  = (req_alg == ALG_SHA512) && !SHA512_EN;

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = two_beat ? ST_LO : ST_ONE;
      ST_LO:   if (rsp_ready) state_nxt = ST_HI;
      ST_ONE, ST_HI: begin
        if (rsp_ready) state_nxt = accept ? (two_beat ? ST_LO : ST_ONE) : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) || (((state == ST_ONE) || (state == ST_HI)) && rsp_ready);
    rsp_valid = (state != ST_IDLE);
    accept    = req_valid && req_ready;
  end

  // Whole result is captured at accept; the HI beat replays the stored upper half.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      res_q  <= '0;
      hi_q   <= '0;
      last_q <= 1'b0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      res_q  <= illegal ? '0 : core_res[XLEN-1:0];
      hi_q   <= two_beat ? core_res[63:32] : '0;
      last_q <= !two_beat;
      ill_q  <= illegal;
    end else if ((state == ST_LO) && rsp_ready) begin
      res_q  <= XLEN'(hi_q);
      last_q <= 1'b1;
    end
  end

  assign rsp_result  = res_q;
  assign rsp_last    = last_q;
  assign rsp_illegal = ill_q;

endmodule
